// File: rtl/fir_window_dmac.sv
// Window generator for one lane of the 2-D FIR core. Buffers three raster
// rows, sends the nine tap coefficients, then one zero-padded 3x3
// neighbourhood per pixel as 9-beat bursts separated by GAP idle cycles.
module fir_window_dmac #(
    parameter int IW  = 1920,
    parameter int IH  = 1080,
    parameter int RGB = 24,
    parameter int GAP = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [9*RGB-1:0] tap_coef,
    input  logic [RGB-1:0]   pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output logic [RGB-1:0]   input_data,
    output logic             valid_dmac,
    output logic             tc_set,
    output logic             frame_done
);

    localparam int NPIX   = IW * IH;
    localparam int CW     = $clog2(NPIX + 2 * IW + 2);
    localparam int AW     = $clog2(3 * IW);
    localparam int XW     = $clog2(IW);
    localparam int YW     = (IH > 1) ? $clog2(IH) : 1;
    localparam int GW     = $clog2(GAP + 1);
    localparam int STAGES = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_TAP, S_GAP, S_WAIT, S_WIN, S_DONE
    } state_t;

    state_t              state;
    logic [8:0][RGB-1:0] coef_sr;
    logic [CW-1:0]       p_cnt;
    logic [CW-1:0]       w_cnt;
    logic [3:0]          beat;
    logic [GW-1:0]       gcnt;
    logic [XW-1:0]       wcol;
    logic [YW-1:0]       wrow;
    logic [1:0]          wrm3;
    logic [AW-1:0]       waddr;
    logic [AW-1:0]       raddr;

    logic [RGB-1:0]      mem [3*IW];
    logic [RGB-1:0]      rd_q;

    // vld_pipe[0]: beat read issued, vld_pipe[STAGES]: beat on the output
    logic [STAGES:0]     vld_pipe;
    logic                tap1;
    logic                zero1;
    logic                done1;
    logic [RGB-1:0]      coef1;

    logic                active;
    logic                accept;
    logic                eligible;
    logic                req_v;
    logic [1:0]          br;
    logic [1:0]          bc;
    logic [2:0]          srow_t;
    logic [1:0]          srow;
    logic                row_oob;
    logic                col_oob;
    int                  ra;

    assign active   = (state == S_TAP) || (state == S_GAP) ||
                      (state == S_WAIT) || (state == S_WIN);
    // Acceptance bound keeps the oldest row still needed by window W unclobbered
    assign pix_ready = active && (p_cnt < CW'(NPIX)) &&
                       (p_cnt <= w_cnt + CW'(2 * IW - 2));
    assign accept   = pix_valid & pix_ready;
    // Window W needs pixel W+IW+1; at the end of the image everything is in
    assign eligible = (p_cnt >= w_cnt + CW'(IW + 2)) || (p_cnt == CW'(NPIX));
    assign req_v    = (state == S_TAP) || (state == S_WIN);

    // Decode the beat into a neighbourhood offset and a line-buffer address
    always_comb begin
        br = 2'd0;
        bc = beat[1:0];
        if (beat >= 4'd6) begin
            br = 2'd2;
            bc = 2'(beat - 4'd6);
        end else if (beat >= 4'd3) begin
            br = 2'd1;
            bc = 2'(beat - 4'd3);
        end
        row_oob = ((br == 2'd0) && (wrow == '0)) ||
                  ((br == 2'd2) && (wrow == YW'(IH - 1)));
        col_oob = ((bc == 2'd0) && (wcol == '0)) ||
                  ((bc == 2'd2) && (wcol == XW'(IW - 1)));
        // row slot = (j + br - 1) mod 3
        srow_t = {1'b0, wrm3} + {1'b0, br} + 3'd2;
        if (srow_t >= 3'd6)      srow_t = srow_t - 3'd6;
        else if (srow_t >= 3'd3) srow_t = srow_t - 3'd3;
        srow = srow_t[1:0];
        ra = int'(srow) * IW + int'(wcol) + int'(bc) - 1;
        if (col_oob) ra = int'(srow) * IW;
        raddr = AW'(ra);
    end

    // Frame sequencing, pixel counting and window position tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            coef_sr <= '0;
            p_cnt   <= '0;
            w_cnt   <= '0;
            beat    <= '0;
            gcnt    <= '0;
            wcol    <= '0;
            wrow    <= '0;
            wrm3    <= '0;
            waddr   <= '0;
        end else begin
            if (accept) begin
                p_cnt <= p_cnt + CW'(1);
                waddr <= (waddr == AW'(3 * IW - 1)) ? '0 : waddr + AW'(1);
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        coef_sr <= tap_coef;
                        beat    <= '0;
                        state   <= S_TAP;
                    end
                end
                S_TAP: begin
                    coef_sr <= {{RGB{1'b0}}, coef_sr[8:1]};
                    beat    <= beat + 4'd1;
                    if (beat == 4'd8) begin
                        beat  <= '0;
                        gcnt  <= '0;
                        state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (gcnt == GW'(GAP - 1)) begin
                        gcnt <= '0;
                        if (w_cnt == CW'(NPIX)) state <= S_DONE;
                        else if (eligible)      state <= S_WIN;
                        else                    state <= S_WAIT;
                    end else begin
                        gcnt <= gcnt + GW'(1);
                    end
                end
                S_WAIT: begin
                    if (eligible) state <= S_WIN;
                end
                S_WIN: begin
                    beat <= beat + 4'd1;
                    if (beat == 4'd8) begin
                        beat  <= '0;
                        w_cnt <= w_cnt + CW'(1);
                        state <= S_GAP;
                        if (wcol == XW'(IW - 1)) begin
                            wcol <= '0;
                            wrow <= wrow + YW'(1);
                            wrm3 <= (wrm3 == 2'd2) ? 2'd0 : wrm3 + 2'd1;
                        end else begin
                            wcol <= wcol + XW'(1);
                        end
                    end
                end
                S_DONE: begin
                    p_cnt <= '0;
                    w_cnt <= '0;
                    wcol  <= '0;
                    wrow  <= '0;
                    wrm3  <= '0;
                    waddr <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Line buffer: write accepted pixels, synchronous read for the beat pipe
    always_ff @(posedge clk) begin
        if (accept) mem[waddr] <= pix_in;
        rd_q <= mem[raddr];
    end

    // Two-stage beat pipe: read/select stage, then registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe   <= '0;
            tap1       <= 1'b0;
            zero1      <= 1'b0;
            done1      <= 1'b0;
            coef1      <= '0;
            input_data <= '0;
            tc_set     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            vld_pipe   <= {vld_pipe[STAGES-1:0], req_v};
            tap1       <= (state == S_TAP);
            zero1      <= (state == S_WIN) && (row_oob || col_oob);
            done1      <= (state == S_DONE);
            coef1      <= coef_sr[0];
            tc_set     <= vld_pipe[0] & tap1;
            frame_done <= done1;
            if (!vld_pipe[0] || zero1) input_data <= '0;
            else if (tap1)             input_data <= coef1;
            else                       input_data <= rd_q;
        end
    end

    assign valid_dmac = vld_pipe[STAGES];

endmodule
